// File: rtl/ram_access_ctrl.sv
// RAM front end arbitrating CPU req/ack and a byte-stream loader.
// All RAM strobes, cpu_ack and cpu_rdata are registered.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned LOAD_BASE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_do
);

  localparam int unsigned CNT_W =
    $clog2(RD_LATENCY + 1) + 1;
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(LOAD_BASE);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_ACK,
    S_LOAD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              en_q, en_d;
  logic [1:0]        we_q, we_d;
  logic              regce_q, regce_d;
  logic              rst_q;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and output registers; RAM reset held until first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      di_q    <= '0;
      en_q    <= 1'b0;
      we_q    <= 2'b00;
      regce_q <= 1'b0;
      rst_q   <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= BASE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      en_q    <= en_d;
      we_q    <= we_d;
      regce_q <= regce_d;
      rst_q   <= 1'b0;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic; strobes default low each cycle
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    di_d    = di_q;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    we_d    = 2'b00;
    regce_d = 1'b0;
    ack_d   = 1'b0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          state_d = S_LOAD;
          ptr_d   = BASE;
          busy_d  = 1'b1;
          ready_d = 1'b1;
        end else if (cpu_req) begin
          addr_d = cpu_addr;
          di_d   = cpu_wdata;
          en_d   = 1'b1;
          we_d   = {2{cpu_we}};
          cnt_d  = '0;
          if (cpu_we) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
            regce_d = 1'b1;
          end
        end
      end
      S_WR: begin
        state_d = S_ACK;
        ack_d   = 1'b1;
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = ram_do;
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          regce_d = 1'b1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_LOAD: begin
        busy_d  = 1'b1;
        ready_d = 1'b1;
        if (ld_valid) begin
          addr_d = ptr_q;
          di_d   = ld_data;
          en_d   = 1'b1;
          we_d   = 2'b11;
          ptr_d  = ptr_q + ADDR_W'(1);
          if (ld_last) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign ld_ready  = ready_q;
  assign ld_busy   = busy_q;
  assign ram_addr  = addr_q;
  assign ram_di    = di_q;
  assign ram_en    = en_q;
  assign ram_we    = we_q;
  assign ram_regce = regce_q;
  assign ram_rst   = rst_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two instances (read latency 1 and 2),
// each with a behavioural RAM, checked against a byte-array reference.
module tb_ram_access_ctrl;

  localparam int LAT0 = 1;
  localparam int LAT1 = 2;
  localparam logic [14:0] BASE0 = 15'h7FFE;
  localparam logic [14:0] BASE1 = 15'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req [2];
  logic        cpu_we [2];
  logic [14:0] cpu_addr [2];
  logic [7:0]  cpu_wdata [2];
  logic        cpu_ack [2];
  logic [7:0]  cpu_rdata [2];
  logic        ld_start [2];
  logic        ld_valid [2];
  logic        ld_last [2];
  logic [7:0]  ld_data [2];
  logic        ld_ready [2];
  logic        ld_busy [2];
  logic [14:0] ram_addr [2];
  logic [7:0]  ram_di [2];
  logic        ram_en [2];
  logic [1:0]  ram_we [2];
  logic        ram_regce [2];
  logic        ram_rst [2];
  logic [7:0]  ram_do [2];

  int checks = 0;
  int errors = 0;
  logic [7:0]  refm [2][32768];
  logic [7:0]  last_rd [2];
  logic [14:0] pool [2][6];

  always #5 clk = ~clk;

  ram_access_ctrl #(
    .ADDR_W(15), .DATA_W(8),
    .RD_LATENCY(LAT0), .LOAD_BASE(32'h7FFE)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]),
    .cpu_addr(cpu_addr[0]),
    .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]),
    .cpu_rdata(cpu_rdata[0]),
    .ld_start(ld_start[0]),
    .ld_valid(ld_valid[0]),
    .ld_last(ld_last[0]),
    .ld_data(ld_data[0]),
    .ld_ready(ld_ready[0]),
    .ld_busy(ld_busy[0]),
    .ram_addr(ram_addr[0]),
    .ram_di(ram_di[0]),
    .ram_en(ram_en[0]),
    .ram_we(ram_we[0]),
    .ram_regce(ram_regce[0]),
    .ram_rst(ram_rst[0]),
    .ram_do(ram_do[0])
  );

  ram_access_ctrl #(
    .ADDR_W(15), .DATA_W(8),
    .RD_LATENCY(LAT1), .LOAD_BASE(32'h0000)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]),
    .cpu_addr(cpu_addr[1]),
    .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]),
    .cpu_rdata(cpu_rdata[1]),
    .ld_start(ld_start[1]),
    .ld_valid(ld_valid[1]),
    .ld_last(ld_last[1]),
    .ld_data(ld_data[1]),
    .ld_ready(ld_ready[1]),
    .ld_busy(ld_busy[1]),
    .ram_addr(ram_addr[1]),
    .ram_di(ram_di[1]),
    .ram_en(ram_en[1]),
    .ram_we(ram_we[1]),
    .ram_regce(ram_regce[1]),
    .ram_rst(ram_rst[1]),
    .ram_do(ram_do[1])
  );

  // Block RAM models: instance 0 unregistered, instance 1 with DO register
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [7:0] mem [32768];
    logic [7:0] lat_q;
    logic [7:0] reg_q;
    always @(posedge clk) begin
      if (ram_rst[g]) begin
        lat_q <= 8'h00;
      end else if (ram_en[g]) begin
        if (ram_we[g] == 2'b11)
          mem[ram_addr[g]] <= ram_di[g];
        lat_q <= mem[ram_addr[g]];
      end
      if (ram_rst[g])
        reg_q <= 8'h00;
      else if (ram_regce[g])
        reg_q <= lat_q;
    end
    assign ram_do[g] = (g == 0) ? lat_q : reg_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Caller guarantees the instance is idle when this starts
  task automatic cpu_op(input int k, input bit we,
                        input logic [14:0] a,
                        input logic [7:0] d);
    int n;
    int lat;
    bit got;
    lat = lat_of(k);
    cpu_req[k] = 1'b1;
    cpu_we[k] = we;
    cpu_addr[k] = a;
    cpu_wdata[k] = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        chk("strobe_en", 32'(ram_en[k]), 1);
        chk("strobe_we", 32'(ram_we[k]),
            we ? 32'd3 : 32'd0);
        chk("strobe_addr", 32'(ram_addr[k]), 32'(a));
        if (we)
          chk("strobe_di", 32'(ram_di[k]), 32'(d));
        else
          chk("rd_regce", 32'(ram_regce[k]), 1);
      end else if (!we && n <= 1 + lat) begin
        chk("rd_regce_hold", 32'(ram_regce[k]), 1);
        chk("rd_en_low", 32'(ram_en[k]), 0);
      end
      got = cpu_ack[k];
    end
    cpu_req[k] = 1'b0;
    chk(we ? "wr_ack_lat" : "rd_ack_lat", n,
        we ? 2 : 2 + lat);
    if (we) begin
      refm[k][a] = d;
      chk("rdata_hold", 32'(cpu_rdata[k]),
          32'(last_rd[k]));
    end else begin
      chk("rdata", 32'(cpu_rdata[k]),
          32'(refm[k][a]));
      last_rd[k] = refm[k][a];
    end
    tick();
    chk("ack_pulse", 32'(cpu_ack[k]), 0);
  endtask

  // Load session; gap_at inserts one idle cycle before that byte
  task automatic load(input int k,
                      input logic [7:0] bytes[$],
                      input int gap_at);
    int n;
    logic [14:0] ptr;
    ptr = (k == 0) ? BASE0 : BASE1;
    ld_start[k] = 1'b1;
    n = 0;
    while (!ld_busy[k] && n < 10) begin
      tick();
      n++;
    end
    chk("ld_busy_up", 32'(ld_busy[k]), 1);
    chk("ld_ready_up", 32'(ld_ready[k]), 1);
    ld_start[k] = 1'b0;
    foreach (bytes[i]) begin
      if (i == gap_at) begin
        ld_valid[k] = 1'b0;
        tick();
        chk("gap_en", 32'(ram_en[k]), 0);
        chk("gap_we", 32'(ram_we[k]), 0);
        chk("gap_ready", 32'(ld_ready[k]), 1);
      end
      ld_valid[k] = 1'b1;
      ld_data[k] = bytes[i];
      ld_last[k] = (i == bytes.size() - 1);
      tick();
      chk("ld_en", 32'(ram_en[k]), 1);
      chk("ld_we", 32'(ram_we[k]), 3);
      chk("ld_addr", 32'(ram_addr[k]), 32'(ptr));
      chk("ld_di", 32'(ram_di[k]), 32'(bytes[i]));
      chk("ld_noack", 32'(cpu_ack[k]), 0);
      refm[k][ptr] = bytes[i];
      ptr = ptr + 15'd1;
    end
    ld_valid[k] = 1'b0;
    ld_last[k] = 1'b0;
    chk("ld_busy_down", 32'(ld_busy[k]), 0);
    chk("ld_ready_down", 32'(ld_ready[k]), 0);
  endtask

  task automatic chk_reset_outs(input int k);
    chk("rst_ack", 32'(cpu_ack[k]), 0);
    chk("rst_rdata", 32'(cpu_rdata[k]), 0);
    chk("rst_en", 32'(ram_en[k]), 0);
    chk("rst_we", 32'(ram_we[k]), 0);
    chk("rst_regce", 32'(ram_regce[k]), 0);
    chk("rst_busy", 32'(ld_busy[k]), 0);
    chk("rst_ready", 32'(ld_ready[k]), 0);
    chk("rst_addr", 32'(ram_addr[k]), 0);
    chk("rst_di", 32'(ram_di[k]), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    bit got;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cpu_req[k] = 1'b0;
      cpu_we[k] = 1'b0;
      cpu_addr[k] = '0;
      cpu_wdata[k] = '0;
      ld_start[k] = 1'b0;
      ld_valid[k] = 1'b0;
      ld_last[k] = 1'b0;
      ld_data[k] = '0;
      last_rd[k] = 8'h00;
    end

    // Reset state and release
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ramrst", 32'(ram_rst[k]), 1);
      chk_reset_outs(k);
    end
    rst_n = 1'b1;
    #1;
    chk("ramrst_before_edge", 32'(ram_rst[0]), 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("ramrst_after_edge", 32'(ram_rst[k]), 0);
      chk_reset_outs(k);
    end

    // Write then read, latency 1 and latency 2
    cpu_op(0, 1'b1, 15'h0123, 8'h5A);
    cpu_op(0, 1'b0, 15'h0123, 8'h00);
    chk("t2_rdata", 32'(cpu_rdata[0]), 32'h5A);
    cpu_op(1, 1'b1, 15'h0123, 8'h5A);
    cpu_op(1, 1'b0, 15'h0123, 8'h00);
    chk("t3_rdata", 32'(cpu_rdata[1]), 32'h5A);

    // Load across the top of the address space
    q = '{8'h11, 8'h22, 8'h33};
    load(0, q, 1);
    cpu_op(0, 1'b0, 15'h7FFE, 8'h00);
    chk("t4_7ffe", 32'(cpu_rdata[0]), 32'h11);
    cpu_op(0, 1'b0, 15'h7FFF, 8'h00);
    chk("t4_7fff", 32'(cpu_rdata[0]), 32'h22);
    cpu_op(0, 1'b0, 15'h0000, 8'h00);
    chk("t4_0000", 32'(cpu_rdata[0]), 32'h33);

    // Load and CPU read requested in the same cycle
    cpu_req[0] = 1'b1;
    cpu_we[0] = 1'b0;
    cpu_addr[0] = 15'h7FFE;
    q = '{8'h11, 8'h44};
    load(0, q, -1);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = cpu_ack[0];
    end
    cpu_req[0] = 1'b0;
    chk("t5_ack_lat", n, 2 + LAT0);
    chk("t5_rdata", 32'(cpu_rdata[0]), 32'h11);
    last_rd[0] = 8'h11;
    tick();

    // Reset in the middle of a read
    cpu_req[0] = 1'b1;
    cpu_we[0] = 1'b0;
    cpu_addr[0] = 15'h0123;
    tick();
    chk("t6_in_rd", 32'(ram_regce[0]), 1);
    rst_n = 1'b0;
    #1;
    cpu_req[0] = 1'b0;
    chk("t6_ramrst", 32'(ram_rst[0]), 1);
    chk_reset_outs(0);
    tick();
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ack[0]) got = 1'b1;
    end
    chk("t6_no_ack", 32'(got), 0);
    cpu_op(0, 1'b0, 15'h0123, 8'h00);
    chk("t6_rdata", 32'(cpu_rdata[0]), 32'h5A);

    // Randomised traffic against the reference model
    for (int k = 0; k < 2; k++) begin
      pool[k][0] = 15'h0000;
      pool[k][1] = 15'h7FFF;
      for (int i = 2; i < 6; i++)
        pool[k][i] = 15'($urandom);
      for (int i = 0; i < 6; i++)
        cpu_op(k, 1'b1, pool[k][i], 8'($urandom));
    end
    for (int k = 0; k < 2; k++) begin
      q = {};
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        q.push_back(8'($urandom));
      load(k, q, $urandom_range(0, n));
    end
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 1);
      cpu_op(k, 1'($urandom_range(0, 1)),
             pool[k][$urandom_range(0, 5)],
             8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
